// File: rtl/mem_1rw_arbiter.sv
// mem_1rw_arbiter: two-requester round-robin arbiter in front of one
// single-port RAM (read latency 1). Each requester gets a registered,
// backpressured response slot. Optional build macro MEM_1RW_ARB_BOUNDS_EN
// suppresses RAM access for addresses >= DEPTH and flags them with err=1.

// Per-requester response slot: tracks the in-flight access and holds the
// response until the requester consumes it.
module mem_1rw_arb_slot #(
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req_valid,
  input  logic              i_resp_ready,
  input  logic              i_grant,
  input  logic              i_write,
  input  logic              i_oob,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_elig,
  output logic              o_resp_valid,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_err
);
  logic              r_pend;
  logic              r_pend_zero;  // write ack or range error: no RAM data
  logic              r_pend_err;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_err;

  // A slot may issue only when nothing is in flight and the response
  // register will be empty (or popped) by the time the capture lands.
  assign o_elig = i_req_valid & ~r_pend & (~r_resp_valid | i_resp_ready);

  // Remember what kind of access went out so the capture knows what to load.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pend      <= 1'b0;
      r_pend_zero <= 1'b0;
      r_pend_err  <= 1'b0;
    end else begin
      r_pend      <= i_grant;
      r_pend_zero <= i_grant & (i_write | i_oob);
      r_pend_err  <= i_grant & i_oob;
    end
  end

  // Response register: capture has priority over a pop in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else if (r_pend) begin
      r_resp_valid <= 1'b1;
      r_resp_rdata <= r_pend_zero ? '0 : i_ram_rdata;
      r_resp_err   <= r_pend_err;
    end else if (r_resp_valid & i_resp_ready) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;
endmodule

module mem_1rw_arbiter #(
  parameter int DEPTH  = 48,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_rdata,
  output logic              resp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic              resp1_err,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);
  localparam int NUM_REQ = 2;

  logic [NUM_REQ-1:0]             w_req_valid;
  logic [NUM_REQ-1:0]             w_req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] w_req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] w_req_wdata;
  logic [NUM_REQ-1:0]             w_resp_ready;
  logic [NUM_REQ-1:0]             w_elig;
  logic [NUM_REQ-1:0]             w_grant;
  logic [NUM_REQ-1:0]             w_resp_valid;
  logic [NUM_REQ-1:0][DATA_W-1:0] w_resp_rdata;
  logic [NUM_REQ-1:0]             w_resp_err;
  logic                           w_sel;
  logic                           w_oob;
  logic                           r_last;

  assign w_req_valid  = {req1_valid, req0_valid};
  assign w_req_write  = {req1_write, req0_write};
  assign w_req_addr   = {req1_addr, req0_addr};
  assign w_req_wdata  = {req1_wdata, req0_wdata};
  assign w_resp_ready = {resp1_ready, resp0_ready};

  // Round-robin grant; a tie goes to the requester not granted last.
  // Nothing is granted while reset is high so no access leaks out.
  always_comb begin
    w_grant = '0;
    if (!reset) begin
      case (w_elig)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end
  end

  // Without a grant the mux defaults to req0 so addr/wdata stay quiet.
  assign w_sel = w_grant[1];

`ifdef MEM_1RW_ARB_BOUNDS_EN
  assign w_oob = ({1'b0, w_req_addr[w_sel]} >= (ADDR_W+1)'(DEPTH));
`else
  assign w_oob = 1'b0;
`endif

  assign RW0_en    = (|w_grant) & ~w_oob;
  assign RW0_wmode = RW0_en & w_req_write[w_sel];
  assign RW0_addr  = w_req_addr[w_sel];
  assign RW0_wdata = w_req_wdata[w_sel];

  // Track the most recent winner; reset favours req0 on the first tie.
  always_ff @(posedge clock) begin
    if (reset)          r_last <= 1'b1;
    else if (|w_grant)  r_last <= w_grant[1];
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    mem_1rw_arb_slot #(.DATA_W(DATA_W)) u_slot (
      .clock        (clock),
      .reset        (reset),
      .i_req_valid  (w_req_valid[g]),
      .i_resp_ready (w_resp_ready[g]),
      .i_grant      (w_grant[g]),
      .i_write      (w_req_write[g]),
      .i_oob        (w_oob),
      .i_ram_rdata  (RW0_rdata),
      .o_elig       (w_elig[g]),
      .o_resp_valid (w_resp_valid[g]),
      .o_resp_rdata (w_resp_rdata[g]),
      .o_resp_err   (w_resp_err[g])
    );
  end

  assign req0_ready  = w_grant[0];
  assign req1_ready  = w_grant[1];
  assign resp0_valid = w_resp_valid[0];
  assign resp1_valid = w_resp_valid[1];
  assign resp0_rdata = w_resp_rdata[0];
  assign resp1_rdata = w_resp_rdata[1];
  assign resp0_err   = w_resp_err[0];
  assign resp1_err   = w_resp_err[1];
endmodule
